// File: rtl/bka_modadd_pipe.sv
// Pipelined Brent-Kung adder/subtractor with optional reduction modulo Q.
// Ranks: operand capture, G/P, prefix sum, correction/select.
module bka_modadd_pipe #(
    parameter int WIDTH = 16,
    parameter int Q     = 12289,
    parameter int TAG_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    input  logic [1:0]       op_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] s_o,
    output logic             c_o,
    output logic [TAG_W-1:0] tag_o
);
    localparam int LOG_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] Q_V     = WIDTH'(Q);
    localparam logic [WIDTH-1:0] NEG_Q_V = ~Q_V + {{(WIDTH-1){1'b0}}, 1'b1};

    // Brent-Kung prefix adder; carry-in is folded into the bit-0 generate.
    function automatic logic [WIDTH:0] bk_add(
        input logic [WIDTH-1:0] g_in,
        input logic [WIDTH-1:0] p_in,
        input logic             cin
    );
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH:0]   carry;
        g    = g_in;
        p    = p_in;
        g[0] = g_in[0] | (p_in[0] & cin);
        for (int l = 0; l < LOG_W; l++) begin
            for (int i = (2 << l) - 1; i < WIDTH; i += (2 << l)) begin
                g[i] = g[i] | (p[i] & g[i - (1 << l)]);
                p[i] = p[i] & p[i - (1 << l)];
            end
        end
        for (int l = LOG_W - 2; l >= 0; l--) begin
            for (int i = (3 << l) - 1; i < WIDTH; i += (2 << l)) begin
                g[i] = g[i] | (p[i] & g[i - (1 << l)]);
            end
        end
        carry[0]       = cin;
        carry[WIDTH:1] = g;
        return {carry[WIDTH], p_in ^ carry[WIDTH-1:0]};
    endfunction

    logic             en_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             cin_s;

    logic             v0_r, v1_r, v2_r;
    logic [WIDTH-1:0] a0_r, be0_r;
    logic             cin0_r, cin1_r;
    logic [1:0]       op0_r, op1_r, op2_r;
    logic [TAG_W-1:0] tag0_r, tag1_r, tag2_r;
    logic [WIDTH-1:0] g1_r, p1_r;
    logic [WIDTH-1:0] r1_r;
    logic             k1_r;

    logic [WIDTH:0]   sum1_s;
    logic [WIDTH-1:0] corr_s;
    logic [WIDTH:0]   sum2_s;
    logic [WIDTH-1:0] res_s;
    logic             res_c_s;

    // The whole pipe advances together, only blocked by an unaccepted result.
    assign en_s       = ~out_valid_o | out_ready_i;
    assign in_ready_o = en_s;

    // Operand conditioning: subtraction uses ~b with a forced carry-in of 1.
    always_comb begin
        b_eff_s = b_i;
        cin_s   = 1'b0;
        case (op_i)
            2'd0: begin
                b_eff_s = b_i;
                cin_s   = c_i;
            end
            2'd1, 2'd3: begin
                b_eff_s = ~b_i;
                cin_s   = 1'b1;
            end
            2'd2: begin
                b_eff_s = b_i;
                cin_s   = 1'b0;
            end
            default: begin
                b_eff_s = b_i;
                cin_s   = 1'b0;
            end
        endcase
    end

    // Rank 0: capture conditioned operands on acceptance.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v0_r   <= 1'b0;
            a0_r   <= {WIDTH{1'b0}};
            be0_r  <= {WIDTH{1'b0}};
            cin0_r <= 1'b0;
            op0_r  <= 2'd0;
            tag0_r <= {TAG_W{1'b0}};
        end else if (en_s) begin
            v0_r   <= in_valid_i;
            a0_r   <= a_i;
            be0_r  <= b_eff_s;
            cin0_r <= cin_s;
            op0_r  <= op_i;
            tag0_r <= tag_i;
        end
    end

    // Rank 1: bitwise generate/propagate.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1_r   <= 1'b0;
            g1_r   <= {WIDTH{1'b0}};
            p1_r   <= {WIDTH{1'b0}};
            cin1_r <= 1'b0;
            op1_r  <= 2'd0;
            tag1_r <= {TAG_W{1'b0}};
        end else if (en_s) begin
            v1_r   <= v0_r;
            g1_r   <= a0_r & be0_r;
            p1_r   <= a0_r ^ be0_r;
            cin1_r <= cin0_r;
            op1_r  <= op0_r;
            tag1_r <= tag0_r;
        end
    end

    assign sum1_s = bk_add(g1_r, p1_r, cin1_r);

    // Rank 2: primary sum and carry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v2_r   <= 1'b0;
            r1_r   <= {WIDTH{1'b0}};
            k1_r   <= 1'b0;
            op2_r  <= 2'd0;
            tag2_r <= {TAG_W{1'b0}};
        end else if (en_s) begin
            v2_r   <= v1_r;
            r1_r   <= sum1_s[WIDTH-1:0];
            k1_r   <= sum1_s[WIDTH];
            op2_r  <= op1_r;
            tag2_r <= tag1_r;
        end
    end

    // Correction add and result select; k1|k2 flags a true sum >= Q.
    always_comb begin
        corr_s  = {WIDTH{1'b0}};
        res_s   = r1_r;
        res_c_s = k1_r;
        case (op2_r)
            2'd2:    corr_s = NEG_Q_V;
            2'd3:    corr_s = Q_V;
            default: corr_s = {WIDTH{1'b0}};
        endcase
        sum2_s = bk_add(r1_r & corr_s, r1_r ^ corr_s, 1'b0);
        case (op2_r)
            2'd0, 2'd1: begin
                res_s   = r1_r;
                res_c_s = k1_r;
            end
            2'd2: begin
                res_s   = (k1_r | sum2_s[WIDTH]) ? sum2_s[WIDTH-1:0] : r1_r;
                res_c_s = 1'b0;
            end
            2'd3: begin
                res_s   = k1_r ? r1_r : sum2_s[WIDTH-1:0];
                res_c_s = 1'b0;
            end
            default: begin
                res_s   = r1_r;
                res_c_s = k1_r;
            end
        endcase
    end

    // Rank 3: registered outputs, held while downstream stalls.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            s_o         <= {WIDTH{1'b0}};
            c_o         <= 1'b0;
            tag_o       <= {TAG_W{1'b0}};
        end else if (en_s) begin
            out_valid_o <= v2_r;
            s_o         <= res_s;
            c_o         <= res_c_s;
            tag_o       <= tag2_r;
        end
    end
endmodule

// File: doc/bka_modadd_pipe.md
Name: bka_modadd_pipe

Overview:
Parametrised, 3-stage pipelined Brent-Kung adder/subtractor with optional modular reduction modulo Q. It is the next-generation arithmetic primitive for the NTT butterfly datapath, replacing the fixed 16-bit combinational adder. It supports plain add, plain subtract, modular add and modular subtract, selectable per transaction. A valid/ready handshake and a tag sideband allow it to sit directly between butterfly stages.

Parameters:
WIDTH, 16, operand/result width; power of two, >= 4
Q, 12289, modulus for modes 2/3; 2 <= Q < 2**WIDTH
TAG_W, 8, width of opaque sideband tag carried alongside each operation

Ports:
clk_i  input  1  clock; all state rising-edge
rst_i  input  1  reset, asynchronous, active-high
in_valid_i  input  1  operand transaction valid
in_ready_o  output  1  block can accept transaction this cycle
a_i  input  WIDTH  operand A
b_i  input  WIDTH  operand B
c_i  input  1  carry-in, used in mode 0 only
op_i  input  2  0=add, 1=sub, 2=modadd, 3=modsub
tag_i  input  TAG_W  sideband, returned unmodified
out_valid_o  output  1  result valid
out_ready_i  input  1  downstream accepts result
s_o  output  WIDTH  result
c_o  output  1  carry-out (mode 0) / no-borrow (mode 1); 0 in modes 2/3
tag_o  output  TAG_W  tag of the transaction on s_o

Behaviour:
- Clock clk_i, reset rst_i: asynchronous assert, active-high, synchronous deassert handled by the top level. While rst_i is high, all stage valid bits are 0, out_valid_o=0, s_o=0, c_o=0, tag_o=0.
- Handshake: a transfer occurs when valid and ready are both high on the same edge.
  - Global advance enable en = !out_valid_o || out_ready_i.
  - in_ready_o = en, combinational from out_valid_o and out_ready_i only; it never depends on in_valid_i.
- Pipeline stalls as a whole. Bubbles are not collapsed.
- Latency is exactly 3 cycles with no stalls: accepted at edge N, out_valid_o=1 after edge N+3.
- Throughput: 1 transaction per cycle.
- While out_valid_o=1 and out_ready_i=0, all stages hold, and s_o, c_o, tag_o are stable.
- Stage 1 (register):
  - Latch a, b, op, tag and effective carry-in: c_i for op 0, 1 for op 1/3, 0 for op 2.
  - Latch b_eff = ~b for op 1/3, b otherwise.
  - Compute G=a&b_eff and P=a^b_eff.
- Stage 2 (register):
  - Brent-Kung prefix tree over WIDTH bits: log2(WIDTH) up-sweep levels, log2(WIDTH)-1 down-sweep levels.
  - Carry-in is folded in as generate at position -1.
  - Register the sum r1 (WIDTH bits) and carry-out k1.
- Stage 3 (register):
  - Second Brent-Kung adder computes the correction r2 = r1 + corr mod 2**WIDTH, with carry k2.
  - corr = -Q (two's complement) for op 2; corr = +Q for op 3.
  - Result select:
    - op 0/1: s=r1, c=k1.
    - op 2: the true sum is {k1,r1}. If {k1,r1} >= Q then s=r2, else s=r1; c=0. The compare uses k1|k2, i.e. true when a carry arises in either add.
    - op 3: if k1=0 (borrow) then s=r2, else s=r1; c=0.
- Both adders must be generic Brent-Kung prefix networks generated from WIDTH; a ripple or behavioural '+' is not permitted in the datapath.
- Modes 2/3 require a,b < Q.
  - Out-of-range operands produce the formula result above, unreduced.
  - No error is flagged.
- Simultaneous accept and emit in the same cycle is legal and must not drop or duplicate a transaction.
- Reset mid-operation: all in-flight transactions are discarded and no output appears after release.
- op_i, c_i, a_i, b_i and tag_i are don't-care when in_valid_i=0.

Test Plan:
- Mode 0, WIDTH=16, a=0xFFFF, b=0x0001, c_i=0 -> 3 cycles later s_o=0x0000, c_o=1; with c_i=1 -> s_o=0x0001, c_o=1.
- Mode 1, a=5, b=7 -> s_o=0xFFFE, c_o=0; a=7, b=5 -> s_o=0x0002, c_o=1.
- Mode 2, Q=12289:
  - a=12288, b=1 -> s_o=0.
  - a=6000, b=6000 -> s_o=12000.
  - a=12288, b=12288 -> s_o=12287.
  - c_o=0 in all three cases.
- Mode 3: a=3, b=5 -> s_o=12287; a=5, b=3 -> s_o=2; a=0, b=0 -> s_o=0.
- Backpressure: issue 6 back-to-back ops with tags 1..6, hold out_ready_i=0 for 4 cycles once out_valid_o rises.
  - in_ready_o=0 during the stall.
  - s_o and tag_o are stable while stalled.
  - All 6 results emerge in tag order; none lost or duplicated.
- Reset mid-flight with 2 ops in the pipe: out_valid_o drops to 0 asynchronously, and nothing is emitted after release.
- Random soak over WIDTH in {8,16,32}: 10k random in-range ops with random in_valid_i and out_ready_i, compared against a golden model.
